// File: rtl/cam_frame_ctrl.sv
// cam_frame_ctrl: camera frame capture controller writing strobed pixels into a linear frame buffer.
// Ports: pclk/reset (async, active-high); start/stop/continuous commands; vsync frame sync;
// pixel_valid/x_coord (1-based)/y_coord (0-based)/pixel_data pixel stream;
// wr_en/wr_addr/wr_data registered frame-buffer write port; busy, frame_done pulse, frame_count.
// Optional macro CAM_FRAME_CTRL_STATS_EN adds pix_count (writes in last frame) and drop_count.
module cam_frame_ctrl #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic              vsync,
  input  logic              pixel_valid,
  input  logic [9:0]        x_coord,
  input  logic [9:0]        y_coord,
  input  logic [7:0]        pixel_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        frame_count
`ifdef CAM_FRAME_CTRL_STATS_EN
  ,
  output logic [ADDR_W-1:0] pix_count,
  output logic [15:0]       drop_count
`endif
);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  state_t            state_q;
  logic              vsync_q;
  logic              stop_pend_q;
  logic              vs_rise;
  logic              capt;
  logic              in_range;
  logic              wr_d;
  logic [ADDR_W-1:0] addr_d;
  assign vs_rise  = vsync & ~vsync_q;
  assign capt     = (state_q == CAPTURE) && pixel_valid;
  assign in_range = (x_coord != 10'd0) && (int'(x_coord) <= H_RES) && (int'(y_coord) < V_RES);
  assign wr_d     = capt && in_range;
  assign addr_d   = ADDR_W'(y_coord) * ADDR_W'(H_RES) + ADDR_W'(x_coord) - ADDR_W'(1);
  assign busy       = state_q != IDLE;
  assign frame_done = state_q == DONE;
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      vsync_q     <= 1'b0;
      stop_pend_q <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_count <= '0;
    end else begin
      vsync_q <= vsync;
      wr_en   <= wr_d;
      if (wr_d) begin
        wr_addr <= addr_d;
        wr_data <= pixel_data;
      end
      case (state_q)
        IDLE:    if (start && !stop) state_q <= ARMED;
        ARMED:   state_q <= stop ? IDLE : vs_rise ? CAPTURE : ARMED;
        CAPTURE: begin
          if (stop) stop_pend_q <= 1'b1;
          if (vs_rise) begin
            state_q     <= DONE;
            frame_count <= frame_count + 8'd1;
          end
        end
        default: begin
          state_q     <= (continuous && !stop_pend_q && !stop) ? ARMED : IDLE;
          stop_pend_q <= 1'b0;
        end
      endcase
    end
  end
`ifdef CAM_FRAME_CTRL_STATS_EN
  logic [ADDR_W-1:0] frame_pix_q;
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      frame_pix_q <= '0;
      pix_count   <= '0;
      drop_count  <= '0;
    end else begin
      frame_pix_q <= (state_q == CAPTURE && !vs_rise) ? frame_pix_q + ADDR_W'(wr_d) : '0;
      if (state_q == CAPTURE && vs_rise) pix_count <= frame_pix_q + ADDR_W'(wr_d);
      if (capt && !in_range && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cam_frame_ctrl.sv
// tb_cam_frame_ctrl: self-checking bench for cam_frame_ctrl (vector table, corner sequences, random vs model).
module tb_cam_frame_ctrl;
  localparam int H = 640;
  localparam int V = 480;
  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, stop = 1'b0, continuous = 1'b0, vsync = 1'b0, pixel_valid = 1'b0;
  logic [9:0]  x_coord = '0, y_coord = '0;
  logic [7:0]  pixel_data = '0;
  logic        wr_en, busy, frame_done;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data, frame_count;
`ifdef CAM_FRAME_CTRL_STATS_EN
  logic [18:0] pix_count;
  logic [15:0] drop_count;
`endif
  int n_chk = 0, n_fail = 0, n_wr = 0;
  cam_frame_ctrl dut (
    .pclk(pclk), .reset(reset), .start(start), .stop(stop), .continuous(continuous),
    .vsync(vsync), .pixel_valid(pixel_valid), .x_coord(x_coord), .y_coord(y_coord),
    .pixel_data(pixel_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
`ifdef CAM_FRAME_CTRL_STATS_EN
    , .pix_count(pix_count), .drop_count(drop_count)
`endif
  );
  always #5 pclk = ~pclk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // reference model: capture phase as a name, expectations as plain arithmetic
  typedef enum int {M_IDLE, M_WAIT, M_GRAB, M_END} mphase_t;
  mphase_t m_ph;
  bit m_vs_prev, m_quit, e_wr;
  int e_addr, e_data, e_frames;
  function automatic void model_reset();
    m_ph = M_IDLE; m_vs_prev = 0; m_quit = 0; e_wr = 0; e_addr = 0; e_data = 0; e_frames = 0;
  endfunction
  function automatic void model_step();
    bit edge_up = vsync && !m_vs_prev;
    int x = int'(x_coord), y = int'(y_coord);
    m_vs_prev = vsync;
    e_wr = (m_ph == M_GRAB) && pixel_valid && x >= 1 && x <= H && y < V;
    if (e_wr) begin
      e_addr = y * H + x - 1;
      e_data = int'(pixel_data);
    end
    if (m_ph == M_END) begin
      m_ph = (continuous && !m_quit && !stop) ? M_WAIT : M_IDLE;
      m_quit = 0;
    end else if (m_ph == M_GRAB) begin
      m_quit = m_quit | stop;
      if (edge_up) begin
        m_ph = M_END;
        e_frames = (e_frames + 1) % 256;
      end
    end else if (m_ph == M_WAIT) m_ph = stop ? M_IDLE : edge_up ? M_GRAB : M_WAIT;
    else if (start && !stop) m_ph = M_WAIT;
  endfunction
  task automatic step();
    model_step();
    @(posedge pclk);
    #1;
    if (wr_en) n_wr++;
    chk("wr_en", 32'(wr_en), 32'(e_wr));
    chk("wr_addr", 32'(wr_addr), 32'(e_addr));
    chk("wr_data", 32'(wr_data), 32'(e_data));
    chk("busy", 32'(busy), 32'(m_ph != M_IDLE));
    chk("frame_done", 32'(frame_done), 32'(m_ph == M_END));
    chk("frame_count", 32'(frame_count), 32'(e_frames));
  endtask
  task automatic reset_dut();
    reset = 1;
    {start, stop, continuous, vsync, pixel_valid} = '0;
    x_coord = '0; y_coord = '0; pixel_data = '0;
    model_reset();
    @(posedge pclk);
    #1;
    reset = 0;
    n_wr = 0;
  endtask
  task automatic period(input bit do_stop);
    vsync = 1; pixel_valid = 0;
    step(); step();
    vsync = 0;
    for (int i = 0; i < 10; i++) begin
      pixel_valid = 1;
      x_coord = 10'($urandom_range(1, H));
      y_coord = 10'($urandom_range(0, V - 1));
      pixel_data = 8'($urandom);
      stop = do_stop && i == 5;
      step();
    end
    pixel_valid = 0; stop = 0;
  endtask
  typedef struct {
    bit st, sp, ct, vs, pv;
    int x, y, d;
    bit o_wr;
    int o_addr, o_data;
    bit o_busy, o_done;
    int o_fc;
  } vec_t;
  vec_t tbl[14];
  initial begin
    tbl[0]  = '{1,1,0,0,0,   0,  0,'h00, 0,     0,'h00, 0,0,0};
    tbl[1]  = '{1,0,0,0,0,   0,  0,'h00, 0,     0,'h00, 1,0,0};
    tbl[2]  = '{0,0,0,1,0,   0,  0,'h00, 0,     0,'h00, 1,0,0};
    tbl[3]  = '{0,0,0,0,1,   1,  0,'hAA, 1,     0,'hAA, 1,0,0};
    tbl[4]  = '{0,0,0,0,1, 640,479,'h55, 1,307199,'h55, 1,0,0};
    tbl[5]  = '{0,0,0,0,1,   0,  0,'h77, 0,307199,'h55, 1,0,0};
    tbl[6]  = '{0,0,0,0,1, 641,  0,'h78, 0,307199,'h55, 1,0,0};
    tbl[7]  = '{0,0,0,0,1,   5,480,'h79, 0,307199,'h55, 1,0,0};
    tbl[8]  = '{0,0,0,1,1,   3,  2,'h11, 1,  1282,'h11, 1,1,1};
    tbl[9]  = '{0,0,0,1,0,   0,  0,'h00, 0,  1282,'h11, 0,0,1};
    tbl[10] = '{0,0,0,0,1,   1,  1,'h22, 0,  1282,'h11, 0,0,1};
    tbl[11] = '{1,0,0,1,0,   0,  0,'h00, 0,  1282,'h11, 1,0,1};
    tbl[12] = '{0,1,0,1,0,   0,  0,'h00, 0,  1282,'h11, 0,0,1};
    tbl[13] = '{0,0,0,0,1,   2,  0,'h33, 0,  1282,'h11, 0,0,1};
    #1;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    reset_dut();
    for (int i = 0; i < 14; i++) begin
      {start, stop, continuous, vsync, pixel_valid} = {tbl[i].st, tbl[i].sp, tbl[i].ct, tbl[i].vs, tbl[i].pv};
      x_coord = 10'(tbl[i].x); y_coord = 10'(tbl[i].y); pixel_data = 8'(tbl[i].d);
      @(posedge pclk);
      #1;
      chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].o_wr));
      chk($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(tbl[i].o_addr));
      chk($sformatf("v%0d_wr_data", i), 32'(wr_data), 32'(tbl[i].o_data));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].o_busy));
      chk($sformatf("v%0d_frame_done", i), 32'(frame_done), 32'(tbl[i].o_done));
      chk($sformatf("v%0d_frame_count", i), 32'(frame_count), 32'(tbl[i].o_fc));
`ifdef CAM_FRAME_CTRL_STATS_EN
      if (i == 8) begin
        chk("drop_count", 32'(drop_count), 3);
        chk("pix_count", 32'(pix_count), 3);
      end
`endif
    end
    // asynchronous reset in the middle of a capture
    {start, stop, vsync, pixel_valid} = '0;
    start = 1; @(posedge pclk); #1;
    start = 0; vsync = 1; @(posedge pclk); #1;
    vsync = 0; pixel_valid = 1; x_coord = 10'd4; y_coord = 10'd0; pixel_data = 8'h5A;
    @(posedge pclk); #1;
    chk("async_pre_wr_en", 32'(wr_en), 1);
    chk("async_pre_frame_count", 32'(frame_count), 1);
    #2 reset = 1;
    #1;
    chk("async_wr_en", 32'(wr_en), 0);
    chk("async_frame_count", 32'(frame_count), 0);
    chk("async_busy", 32'(busy), 0);
    #1 reset = 0;
    for (int i = 0; i < 6; i++) begin
      vsync = (i == 2);
      @(posedge pclk); #1;
      chk("post_rst_wr_en", 32'(wr_en), 0);
      chk("post_rst_busy", 32'(busy), 0);
    end
    // continuous capture, stop during the second captured frame
    reset_dut();
    continuous = 1; start = 1; step(); start = 0;
    period(0); period(0); period(1); period(0);
    chk("cont_frame_count", 32'(frame_count), 2);
    chk("cont_writes", 32'(n_wr), 20);
    period(0); period(0);
    chk("cont_after_stop_writes", 32'(n_wr), 20);
    chk("cont_idle_busy", 32'(busy), 0);
    // randomized traffic against the model
    reset_dut();
    begin
      int per = 50, ph = 0;
      for (int i = 0; i < 4000; i++) begin
        start = ($urandom % 16) == 0;
        stop = ($urandom % 64) == 0;
        if ($urandom % 200 == 0) continuous = ~continuous;
        vsync = ph < 3;
        ph++;
        if (ph == per) begin
          ph = 0;
          per = $urandom_range(20, 60);
        end
        pixel_valid = $urandom % 2;
        x_coord = 10'($urandom_range(0, 645));
        y_coord = 10'($urandom_range(0, 482));
        pixel_data = 8'($urandom);
        step();
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
